input_16: RTL
=============

# input_16

Receive-side counterpart of the 16-bit result serializer. Samples a 10-bit byte-serial bus whose upper 8 bits carry data and lower 2 bits carry a code, and reassembles high-byte-first pairs into 16-bit words. Completed words go into a 2-entry show-ahead FIFO drained by a valid/ready handshake. Sits at the chip input, feeding operands to the compute core; sticky error flags report framing problems.

## Interface

- TIMEOUT, 15: idle cycles allowed between a high byte and its low byte before the partial word is discarded (1..255).
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- in  input  10  in[9:2] = data byte; in[1:0] = code: 11 data, 00 idle, 01 resync, 10 reserved.
- word  output  16  FIFO head word; 0 when empty.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts head when word_valid && word_ready.
- overflow  output  1  sticky: a completed word was dropped because FIFO full.
- timeout_err  output  1  sticky: partial word discarded by timeout.
- frame_err  output  1  sticky: reserved code 10 sampled.
- err_clear  input  1  synchronous clear of the three sticky flags.

## Operation

- Assembler FSM, two states: WAIT_HI (reset state), WAIT_LO.
- WAIT_HI: code 11 -> hi_reg <= in[9:2], idle counter <= 0, go WAIT_LO. Codes 00/01/10 -> stay.
- WAIT_LO: code 11 -> complete word {hi_reg, in[9:2]}, push to FIFO, go WAIT_HI. Code 01 -> drop hi_reg, go WAIT_HI, no error. Code 00/10 -> idle counter +1; when counter reaches TIMEOUT on that edge -> go WAIT_HI, set timeout_err.
- Gaps of up to TIMEOUT-1 idle cycles between high and low byte are tolerated; low byte after exactly TIMEOUT idle cycles is treated as a new high byte.
- Code 10 in any state: set frame_err; otherwise behaves as idle.
- FIFO: 2 entries, show-ahead; word = head, word_valid = count != 0.
- Push and pop on the same edge: both take effect; when full, simultaneous pop frees a slot so no overflow.
- Push when full without pop: word discarded, contents unchanged, overflow set.
- Pop when empty: ignored.
- err_clear clears sticky flags; a setting event on the same edge wins (flag stays 1).
- Counter width $clog2(TIMEOUT+1); saturates, never wraps.

## Timing

- Reset (async, immediate): state WAIT_HI, hi_reg 0, counter 0, FIFO empty, word 16'h0000, word_valid 0, overflow 0, timeout_err 0, frame_err 0.
- Inputs sampled on rising edge. Low byte sampled at edge N -> word_valid high and word valid after edge N (cycle N+1). Latency: 1 cycle from low-byte cycle.
- Back-to-back pairs (code 11 every cycle) sustain one word per 2 cycles; with word_ready held high the FIFO never fills.
- Pop at edge M -> next entry (or 0 / word_valid low) visible after edge M.
- Sticky flags set on the edge the event is sampled, visible next cycle.
- Reset mid-word discards hi_reg and all FIFO contents; first byte after reset release is a high byte.

## Test plan

- Basic pair: reset, then in = {8'hAB,2'b11}, {8'hCD,2'b11}, word_ready=1 -> cycle after second byte word=16'hABCD, word_valid=1 for one cycle, then word=0, word_valid=0.
- Gap and timeout (TIMEOUT=15): high 8'h12, 14 idle cycles, low 8'h34 -> word 16'h1234, no error; repeat with 15 idle cycles -> timeout_err=1, no word, 8'h34 held as new high byte.
- Resync: high 8'h55, code 01, then bytes 8'h01, 8'h02 -> single word 16'h0102, all error flags 0.
- Full FIFO: word_ready=0, send pairs 16'h1111, 16'h2222, 16'h3333 -> overflow=1, FIFO holds 16'h1111 then 16'h2222; drain with word_ready=1 -> those two words in order, then empty.
- Simultaneous push/pop while full: FIFO full, word_ready=1 on the edge a third word 16'h4444 completes -> overflow stays 0, reads out 16'h2222 then 16'h4444.
- Frame error and clear: one cycle code 10 -> frame_err=1; err_clear pulse -> 0; err_clear together with code 10 -> frame_err remains 1.

Source files
------------

// File: rtl/input_16.sv
// input_16: byte-serial receiver. Pairs high/low data bytes from a 10-bit
// coded bus into 16-bit words, queues them in a 2-entry show-ahead FIFO and
// keeps sticky flags for dropped words, timed-out partials and bad codes.
module input_16 #(
   parameter int TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [9:0]  in,
   output logic [15:0] word,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        overflow,
   output logic        timeout_err,
   output logic        frame_err,
   input  logic        err_clear
);

   localparam int             CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  TO_V = CW'(TIMEOUT);

   typedef enum logic {WAIT_HI, WAIT_LO} state_t;

   state_t           state;
   logic [7:0]       hi_reg;
   logic [CW-1:0]    cnt;
   logic [1:0][15:0] mem;
   logic [1:0]       count;

   logic [1:0]    code;
   logic          is_data;
   logic          is_gap;
   logic          push;
   logic          pop;
   logic [15:0]   push_word;
   logic [CW-1:0] cnt_inc;
   logic          to_hit;

   assign code      = in[1:0];
   assign is_data   = (code == 2'b11);
   // reserved code is treated as an idle cycle for assembly purposes
   assign is_gap    = (code == 2'b00) || (code == 2'b10);
   assign push      = (state == WAIT_LO) && is_data;
   assign push_word = {hi_reg, in[9:2]};
   assign pop       = word_ready && (count != 2'd0);
   // idle counter saturates at TIMEOUT so it can never wrap back to a small value
   assign cnt_inc   = (cnt == TO_V) ? cnt : cnt + 1'b1;
   assign to_hit    = (state == WAIT_LO) && is_gap && (cnt_inc == TO_V);

   assign word       = (count != 2'd0) ? mem[0] : 16'h0000;
   assign word_valid = (count != 2'd0);

   // assembler FSM plus the timeout/frame sticky flags (set beats clear)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= WAIT_HI;
         hi_reg      <= 8'h00;
         cnt         <= '0;
         timeout_err <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         case (state)
            WAIT_HI: begin
               if (is_data) begin
                  hi_reg <= in[9:2];
                  cnt    <= '0;
                  state  <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (is_data || code == 2'b01) begin
                  state <= WAIT_HI;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == TO_V) state <= WAIT_HI;
               end
            end
            default: state <= WAIT_HI;
         endcase
         timeout_err <= to_hit | (timeout_err & ~err_clear);
         frame_err   <= (code == 2'b10) | (frame_err & ~err_clear);
      end
   end

   // 2-entry FIFO, mem[0] is always the head; a pop frees room for a same-edge push
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem      <= '0;
         count    <= 2'd0;
         overflow <= 1'b0;
      end else begin
         if (push && pop) begin
            if (count == 2'd1) begin
               mem[0] <= push_word;
            end else begin
               mem[0] <= mem[1];
               mem[1] <= push_word;
            end
         end else if (push) begin
            if (count != 2'd2) begin
               mem[count[0]] <= push_word;
               count         <= count + 2'd1;
            end
         end else if (pop) begin
            mem[0] <= mem[1];
            count  <= count - 2'd1;
         end
         overflow <= (push && !pop && count == 2'd2) | (overflow & ~err_clear);
      end
   end

endmodule
